// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the MEM pipeline stage.
package mem_pkg;

  // funct3 encodings for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 encodings for stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // addi x0,x0,0 -- forwarded in place of a trapped access
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    GIVE
  } mem_state_t;

endpackage

// File: rtl/instructions.sv
// instructions: major opcode macros shared by the pipeline stages.
`ifndef INSTRUCTIONS_SV
`define INSTRUCTIONS_SV

`define LOAD  7'b0000011
`define STORE 7'b0100011

`endif

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: byte-lane steering for the MEM stage. Produces byte
// enables and replicated store data, extends load data from the addressed
// lane, and flags accesses that are not naturally aligned.
module mem_lsu_align
  import mem_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic [2:0]         funct3_i,
  input  logic [1:0]         addr_i,
  input  logic [BITSIZE-1:0] rs2_i,
  input  logic [BITSIZE-1:0] rdata_i,
  output logic [3:0]         be_o,
  output logic [BITSIZE-1:0] wdata_o,
  output logic [BITSIZE-1:0] ldata_o,
  output logic               misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte enables and lane-replicated write data, decoded from access size
  // (funct3[1:0]) so loads also present meaningful lane enables.
  always_comb begin
    be_o    = '1;
    wdata_o = rs2_i;
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      F3_SH[1:0]: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{rs2_i[15:0]}};
      end
      F3_SW[1:0]: begin
        be_o    = '1;
        wdata_o = rs2_i;
      end
      default: begin
        be_o    = '1;
        wdata_o = rs2_i;
      end
    endcase
  end

  // Select the addressed lane of read data and sign/zero-extend it.
  always_comb begin
    byte_v  = rdata_i[{addr_i, 3'b000} +: 8];
    half_v  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ldata_o = rdata_i;
    case (funct3_i)
      F3_LB:   ldata_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  ldata_o = {24'h0, byte_v};
      F3_LH:   ldata_o = {{16{half_v[15]}}, half_v};
      F3_LHU:  ldata_o = {16'h0, half_v};
      F3_LW:   ldata_o = rdata_i;
      default: ldata_o = rdata_i;
    endcase
  end

  // Natural alignment: halfwords need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misaligned_o = 1'b0;
      2'b01:   misaligned_o = addr_i[0];
      default: misaligned_o = (addr_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB. Performs LOAD/STORE
// on a single-outstanding data bus using the give/get handshake.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned accesses skip
// the bus and forward a NOP carrying the faulting address.
`include "instructions.sv"

module mem_stage
  import mem_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               resetn_i,
  output logic               MEM_EX_get_o,
  input  logic               EX_MEM_give_i,
  input  logic [31:0]        EX_MEM_instruction_i,
  input  logic [BITSIZE-1:0] EX_MEM_data_i,
  input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
  output logic               MEM_WB_give_o,
  input  logic               WB_MEM_get_i,
  output logic [31:0]        MEM_WB_instruction_o,
  output logic [BITSIZE-1:0] MEM_WB_data_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [3:0]         mem_be_o,
  output logic [BITSIZE-1:0] mem_wdata_o,
  input  logic [BITSIZE-1:0] mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               MEM_misalign_o
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  mem_state_t         state_q;
  logic               get_q;
  logic               give_q;
  logic               req_q;
  logic               misalign_q;
  logic [31:0]        instr_q;
  logic [BITSIZE-1:0] data_q;
  logic [BITSIZE-1:0] rs2_q;

  logic               idle;
  logic               is_mem_in;
  logic               trap_in;
  logic               is_load_q;
  logic               is_store_q;
  logic [2:0]         al_funct3;
  logic [1:0]         al_addr;
  logic [3:0]         al_be;
  logic [BITSIZE-1:0] al_wdata;
  logic [BITSIZE-1:0] al_ldata;
  logic               al_misaligned;

  // One aligner serves both phases: in IDLE it looks at the incoming EX
  // operands to decide on a trap; afterwards at the captured operands.
  always_comb begin
    idle       = (state_q == IDLE);
    is_mem_in  = (EX_MEM_instruction_i[6:0] == `LOAD) ||
                 (EX_MEM_instruction_i[6:0] == `STORE);
    is_load_q  = (instr_q[6:0] == `LOAD);
    is_store_q = (instr_q[6:0] == `STORE);
    al_funct3  = idle ? EX_MEM_instruction_i[14:12] : instr_q[14:12];
    al_addr    = idle ? EX_MEM_data_i[1:0]          : data_q[1:0];
    trap_in    = TrapEn && is_mem_in && al_misaligned;
  end

  mem_lsu_align #(
    .BITSIZE(BITSIZE)
  ) u_align (
    .funct3_i    (al_funct3),
    .addr_i      (al_addr),
    .rs2_i       (rs2_q),
    .rdata_i     (mem_rdata_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .ldata_o     (al_ldata),
    .misaligned_o(al_misaligned)
  );

  // IDLE/ACCESS/GIVE control with registered handshake and request outputs.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      get_q      <= 1'b1;
      give_q     <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      data_q     <= '0;
      rs2_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EX_MEM_give_i) begin
            instr_q <= trap_in ? NOP : EX_MEM_instruction_i;
            data_q  <= EX_MEM_data_i;
            rs2_q   <= EX_MEM_rs2_i;
            get_q   <= 1'b0;
            if (trap_in) begin
              misalign_q <= 1'b1;
              give_q     <= 1'b1;
              state_q    <= GIVE;
            end else if (is_mem_in) begin
              req_q   <= 1'b1;
              state_q <= ACCESS;
            end else begin
              give_q  <= 1'b1;
              state_q <= GIVE;
            end
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            req_q <= 1'b0;
            if (is_load_q) begin
              data_q <= al_ldata;
            end
            give_q  <= 1'b1;
            state_q <= GIVE;
          end
        end
        GIVE: begin
          if (WB_MEM_get_i) begin
            give_q     <= 1'b0;
            misalign_q <= 1'b0;
            get_q      <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          get_q      <= 1'b1;
          give_q     <= 1'b0;
          req_q      <= 1'b0;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  // Bus fields are qualified by the request so they read 0 when idle or in
  // reset; while requesting they come straight from captured registers.
  always_comb begin
    MEM_EX_get_o         = get_q;
    MEM_WB_give_o        = give_q;
    MEM_WB_instruction_o = instr_q;
    MEM_WB_data_o        = data_q;
    MEM_misalign_o       = misalign_q;
    mem_req_o            = req_q;
    mem_we_o             = req_q & is_store_q;
    mem_addr_o           = req_q ? {data_q[31:2], 2'b00} : '0;
    mem_be_o             = req_q ? al_be : '0;
    mem_wdata_o          = req_q ? al_wdata : '0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_get;
  logic        ex_give;
  logic [31:0] ex_instr;
  logic [31:0] ex_data;
  logic [31:0] ex_rs2;
  logic        wb_give;
  logic        wb_get;
  logic [31:0] wb_instr;
  logic [31:0] wb_data;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [3:0]  mbe;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mack;
  logic        misal;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [31:0] I_ADD = 32'h00B5_0533;
  localparam logic [31:0] I_LB  = 32'h0003_0283;
  localparam logic [31:0] I_LH  = 32'h0003_1283;
  localparam logic [31:0] I_LW  = 32'h0003_2283;
  localparam logic [31:0] I_LBU = 32'h0003_4283;
  localparam logic [31:0] I_LHU = 32'h0003_5283;
  localparam logic [31:0] I_SB  = 32'h0073_0023;
  localparam logic [31:0] I_SH  = 32'h0073_1123;
  localparam logic [31:0] I_SW  = 32'h0073_2023;

  always #5 clk = ~clk;

  mem_stage #(
    .BITSIZE(32)
  ) dut (
    .clk                 (clk),
    .resetn_i            (resetn),
    .MEM_EX_get_o        (ex_get),
    .EX_MEM_give_i       (ex_give),
    .EX_MEM_instruction_i(ex_instr),
    .EX_MEM_data_i       (ex_data),
    .EX_MEM_rs2_i        (ex_rs2),
    .MEM_WB_give_o       (wb_give),
    .WB_MEM_get_i        (wb_get),
    .MEM_WB_instruction_o(wb_instr),
    .MEM_WB_data_o       (wb_data),
    .mem_req_o           (mreq),
    .mem_we_o            (mwe),
    .mem_addr_o          (maddr),
    .mem_be_o            (mbe),
    .mem_wdata_o         (mwdata),
    .mem_rdata_i         (mrdata),
    .mem_ack_i           (mack),
    .MEM_misalign_o      (misal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single cycle, then wait one more edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] rs2);
    @(negedge clk);
    chk("get_before_issue", 32'(ex_get), 32'd1);
    ex_give  = 1'b1;
    ex_instr = ins;
    ex_data  = addr;
    ex_rs2   = rs2;
    @(negedge clk);
    ex_give  = 1'b0;
  endtask

  // Full memory transaction: ack arrives in the n-th ACCESS cycle.
  task automatic mem_op(input string nm, input logic [31:0] ins, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rd, input int n,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    logic st;
    st = (ins[6:0] == 7'b0100011);
    issue(ins, addr, rs2);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_req"},  32'(mreq), 32'd1);
      chk({nm, "_addr"}, maddr, exp_addr);
      chk({nm, "_we"},   32'(mwe), 32'(st));
      chk({nm, "_be"},   32'(mbe), 32'(exp_be));
      chk({nm, "_give_in_access"}, 32'(wb_give), 32'd0);
      if (st) chk({nm, "_wdata"}, mwdata, exp_wdata);
      if (i == n - 1) begin
        mack   = 1'b1;
        mrdata = rd;
      end
      @(negedge clk);
    end
    mack   = 1'b0;
    mrdata = '0;
    chk({nm, "_req_off"},  32'(mreq), 32'd0);
    chk({nm, "_give"},     32'(wb_give), 32'd1);
    chk({nm, "_instr"},    wb_instr, ins);
    chk({nm, "_data"},     wb_data, exp_data);
    chk({nm, "_get_busy"}, 32'(ex_get), 32'd0);
    chk({nm, "_misalign"}, 32'(misal), 32'd0);
    wb_get = 1'b1;
    @(negedge clk);
    wb_get = 1'b0;
    chk({nm, "_give_done"}, 32'(wb_give), 32'd0);
    chk({nm, "_get_back"},  32'(ex_get), 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    ex_give  = 1'b0;
    ex_instr = '0;
    ex_data  = '0;
    ex_rs2   = '0;
    wb_get   = 1'b0;
    mrdata   = '0;
    mack     = 1'b0;

    #12;
    chk("rst_get",   32'(ex_get), 32'd1);
    chk("rst_give",  32'(wb_give), 32'd0);
    chk("rst_req",   32'(mreq), 32'd0);
    chk("rst_we",    32'(mwe), 32'd0);
    chk("rst_be",    32'(mbe), 32'd0);
    chk("rst_addr",  maddr, 32'd0);
    chk("rst_instr", wb_instr, 32'd0);
    chk("rst_data",  wb_data, 32'd0);
    chk("rst_mis",   32'(misal), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Non-memory instruction passes through with WB always ready.
    wb_get = 1'b1;
    issue(I_ADD, 32'h0000_1234, 32'h0);
    chk("add_give",  32'(wb_give), 32'd1);
    chk("add_data",  wb_data, 32'h0000_1234);
    chk("add_instr", wb_instr, I_ADD);
    chk("add_req",   32'(mreq), 32'd0);
    @(negedge clk);
    chk("add_give_done", 32'(wb_give), 32'd0);
    chk("add_get_back",  32'(ex_get), 32'd1);
    chk("add_req_after", 32'(mreq), 32'd0);
    wb_get = 1'b0;

    // Loads with lane extraction and extension.
    mem_op("lb",  I_LB,  32'h103, 32'h0, 32'h80FF_0000, 3, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", I_LBU, 32'h103, 32'h0, 32'h80FF_0000, 3, 32'h100, 4'b1000, 32'h0, 32'h0000_0080);
    mem_op("lh",  I_LH,  32'h102, 32'h0, 32'h8001_0000, 1, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001);
    mem_op("lhu", I_LHU, 32'h102, 32'h0, 32'h8001_0000, 1, 32'h100, 4'b1100, 32'h0, 32'h0000_8001);
    mem_op("lw",  I_LW,  32'h104, 32'h0, 32'h7654_3210, 2, 32'h104, 4'b1111, 32'h0, 32'h7654_3210);

    // Stores forward the address to WB.
    mem_op("sb", I_SB, 32'h003, 32'h1234_5678, 32'hFFFF_FFFF, 2, 32'h000, 4'b1000, 32'h7878_7878, 32'h003);
    mem_op("sw", I_SW, 32'h010, 32'hA5A5_1234, 32'hFFFF_FFFF, 1, 32'h010, 4'b1111, 32'hA5A5_1234, 32'h010);

    // SH with same-cycle ack, then 5 cycles of WB backpressure.
    issue(I_SH, 32'h202, 32'hDEAD_BEEF);
    chk("sh_req",   32'(mreq), 32'd1);
    chk("sh_we",    32'(mwe), 32'd1);
    chk("sh_addr",  maddr, 32'h200);
    chk("sh_be",    32'(mbe), 32'hC);
    chk("sh_wdata", mwdata, 32'hBEEF_BEEF);
    mack = 1'b1;
    @(negedge clk);
    mack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_give",  32'(wb_give), 32'd1);
      chk("bp_instr", wb_instr, I_SH);
      chk("bp_data",  wb_data, 32'h202);
      chk("bp_get",   32'(ex_get), 32'd0);
      chk("bp_req",   32'(mreq), 32'd0);
      ex_give  = 1'b1;
      ex_instr = I_ADD;
      ex_data  = 32'h999;
      @(negedge clk);
    end
    ex_give = 1'b0;
    chk("bp_hold_instr", wb_instr, I_SH);
    chk("bp_hold_data",  wb_data, 32'h202);
    wb_get = 1'b1;
    @(negedge clk);
    wb_get = 1'b0;
    chk("bp_give_done", 32'(wb_give), 32'd0);
    chk("bp_get_back",  32'(ex_get), 32'd1);
    @(negedge clk);
    chk("bp_no_capture", 32'(wb_give), 32'd0);

    // Async reset in the middle of ACCESS, then a stray ack.
    issue(I_LW, 32'h400, 32'h0);
    chk("ar_req_pre", 32'(mreq), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_req",  32'(mreq), 32'd0);
    chk("ar_give", 32'(wb_give), 32'd0);
    chk("ar_get",  32'(ex_get), 32'd1);
    chk("ar_addr", maddr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    mack   = 1'b1;
    mrdata = 32'h5555_5555;
    @(negedge clk);
    mack   = 1'b0;
    mrdata = '0;
    chk("stray_req",  32'(mreq), 32'd0);
    chk("stray_give", 32'(wb_give), 32'd0);
    chk("stray_get",  32'(ex_get), 32'd1);
    chk("stray_data", wb_data, 32'd0);

    // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
    issue(I_LW, 32'h301, 32'h0);
    chk("mis_req",   32'(mreq), 32'd0);
    chk("mis_give",  32'(wb_give), 32'd1);
    chk("mis_instr", wb_instr, 32'h0000_0013);
    chk("mis_data",  wb_data, 32'h301);
    chk("mis_flag",  32'(misal), 32'd1);
    wb_get = 1'b1;
    @(negedge clk);
    wb_get = 1'b0;
    chk("mis_flag_off", 32'(misal), 32'd0);
    chk("mis_give_off", 32'(wb_give), 32'd0);
`else
    mem_op("lw_mis", I_LW, 32'h301, 32'h0, 32'hCAFE_F00D, 1, 32'h300, 4'b1111, 32'h0, 32'hCAFE_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
